inv_mix_columns_seq: RTL and testbench
======================================

Name: inv_mix_columns_seq

Overview:
- Iterative controller for the AES-256 decryption round's InvMixColumns step.
- Accepts a 128-bit state over a valid/ready handshake and time-multiplexes one 32-bit inverse-MixColumns column helper across the four columns, one column per clock.
- Returns the transformed state over a valid/ready handshake.
- Sits between InvSubBytes/AddRoundKey and the round register. Also provides a bypass path for the final decryption round, which has no InvMixColumns.

Parameters:
- NUM_COLS, 4, number of 32-bit columns per state; fixed at 4 for AES.
- COL_W, 32, column width in bits.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- flush  in  1  synchronous abort; returns the block to IDLE.
- in_valid  in  1  input state valid.
- in_ready  out  1  block can accept a state.
- in_bypass  in  1  sampled with in_data; 1 means pass the state through unchanged (final round).
- in_data  in  128  state; column 0 = [127:96], column 3 = [31:0].
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  128  transformed state, same column layout as in_data.
- busy  out  1  high in RUN or DONE.
- col_idx  out  2  column currently being processed (debug/visibility).

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-low (rst_n).
- Values while rst_n is low: state=IDLE, in_ready=1, out_valid=0, busy=0, col_idx=0, out_data=0, internal state register=0.
- Handshakes: an input transfer occurs on an edge where in_valid&&in_ready. An output transfer occurs on an edge where out_valid&&out_ready.
- IDLE:
  - in_ready=1.
  - On input transfer: latch in_data into the state register.
  - If in_bypass=1, go to DONE; otherwise go to RUN with col_idx=0.
- RUN:
  - in_ready=0.
  - Each cycle, the helper input is state_reg column[col_idx]. On the edge, that column is overwritten with the helper output and col_idx increments.
  - On the edge where col_idx==3, go to DONE and wrap col_idx to 0.
  - Exactly 4 RUN cycles per state.
- DONE:
  - out_valid=1 and out_data=state_reg, held stable while out_ready=0.
  - On output transfer, go to IDLE.
  - No same-cycle accept of a new input: in_ready is 0 in DONE.
- Latency, non-bypass: input transfer at edge T0, columns written at edges T1..T4, out_valid high from the cycle after T4. Minimum input-to-input interval is 6 cycles.
- Latency, bypass: out_valid high in the cycle after T0, with out_data == latched in_data.
- Column helper:
  - Purely combinational, instantiated exactly once.
  - Output bytes, in GF(2^8) with polynomial 0x11B:
    - b0' = e·b0 ^ b·b1 ^ d·b2 ^ 9·b3
    - b1' = 9·b0 ^ e·b1 ^ b·b2 ^ d·b3
    - b2' = d·b0 ^ 9·b1 ^ e·b2 ^ b·b3
    - b3' = b·b0 ^ d·b1 ^ 9·b2 ^ e·b3
  - b0 is the most significant byte of the column.
- flush:
  - Takes priority over every transition.
  - Next state IDLE, out_valid=0, col_idx=0. The state register keeps its value; its contents are don't-care.
  - flush in IDLE together with in_valid: no transfer happens.
- Async reset mid-RUN or mid-DONE: immediate return to the reset values. The partial state is discarded.
- Inputs are ignored outside IDLE. in_data and in_bypass are sampled only on the transfer edge.
- col_idx is a 2-bit counter. It is never observed above 3, and it is held at 0 in IDLE and DONE.

Decomposition:
- Shared package aes_dec_pkg holds:
  - state enum {IDLE, RUN, DONE}, 2-bit encoding 00/01/10
  - constants NUM_COLS=4, COL_W=32, STATE_W=128
  - a function to extract or insert column i of a 128-bit state
- Sub-module: the existing 32-bit inverse-MixColumns column helper, instantiated once. No new sub-module is required.

Test Plan:
- Non-bypass vector:
  - Stimulus: accept in_data = 8e4da1bc_d5d5d7d6_4d7ebdf8_01010101, bypass=0, out_ready=1.
  - Required: out_data = db135345_d4d4d4d5_2d26314c_01010101, out_valid first high 5 cycles after the transfer edge, held exactly 1 cycle.
- Bypass:
  - Stimulus: accept c6c6c6c6_00112233_deadbeef_0badf00d with in_bypass=1.
  - Required: out_valid the next cycle, out_data identical to the input, 0 helper writes.
- Backpressure:
  - Stimulus: run the non-bypass vector with out_ready=0 for 7 cycles after out_valid, then 1.
  - Required: out_data stable throughout, in_ready=0 throughout, IDLE with in_ready=1 the cycle after release.
- Flush:
  - Stimulus: assert flush when col_idx==2.
  - Required: next cycle IDLE, in_ready=1, out_valid never asserted. A following vector 01010101×4 returns 01010101×4.
- Async reset:
  - Stimulus: drop rst_n mid-RUN, asynchronously to clk.
  - Required: out_valid=0, busy=0, in_ready=1, col_idx=0 before the next edge. After release, the non-bypass vector passes.
- Back-to-back:
  - Stimulus: in_valid held high with 3 states, out_ready=1.
  - Required: transfers exactly 6 cycles apart, results in order, no input accepted while busy=1.

Source files
------------

// File: rtl/aes_dec_pkg.sv
// Shared types and column helpers for the AES decryption datapath.
// A 128-bit state holds four 32-bit columns, column 0 in the top bits.
package aes_dec_pkg;

  localparam int unsigned NUM_COLS = 4;
  localparam int unsigned COL_W    = 32;
  localparam int unsigned STATE_W  = 128;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  function automatic logic [COL_W-1:0] get_col(input logic [STATE_W-1:0] s,
                                               input logic [1:0]         idx);
    logic [COL_W-1:0] c;
    case (idx)
      2'd0:    c = s[127:96];
      2'd1:    c = s[95:64];
      2'd2:    c = s[63:32];
      2'd3:    c = s[31:0];
      default: c = s[127:96];
    endcase
    return c;
  endfunction

  function automatic logic [STATE_W-1:0] set_col(input logic [STATE_W-1:0] s,
                                                 input logic [1:0]         idx,
                                                 input logic [COL_W-1:0]   c);
    logic [STATE_W-1:0] r;
    r = s;
    case (idx)
      2'd0:    r[127:96] = c;
      2'd1:    r[95:64]  = c;
      2'd2:    r[63:32]  = c;
      2'd3:    r[31:0]   = c;
      default: r = s;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/inv_mix_columns_seq_col.sv
// Combinational inverse-MixColumns for one 32-bit column over GF(2^8), poly 0x11B.
// Byte 0 is the most significant byte of the column.
module inv_mix_columns_seq_col (
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Constant multiply built from the x2/x4/x8 doublings selected by k.
  function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (k[0] ? b  : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
           (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
  endfunction

  logic [7:0] b0_s, b1_s, b2_s, b3_s;

  assign b0_s = col_i[31:24];
  assign b1_s = col_i[23:16];
  assign b2_s = col_i[15:8];
  assign b3_s = col_i[7:0];

  assign col_o[31:24] = gf_mul(b0_s, 4'he) ^ gf_mul(b1_s, 4'hb) ^
                        gf_mul(b2_s, 4'hd) ^ gf_mul(b3_s, 4'h9);
  assign col_o[23:16] = gf_mul(b0_s, 4'h9) ^ gf_mul(b1_s, 4'he) ^
                        gf_mul(b2_s, 4'hb) ^ gf_mul(b3_s, 4'hd);
  assign col_o[15:8]  = gf_mul(b0_s, 4'hd) ^ gf_mul(b1_s, 4'h9) ^
                        gf_mul(b2_s, 4'he) ^ gf_mul(b3_s, 4'hb);
  assign col_o[7:0]   = gf_mul(b0_s, 4'hb) ^ gf_mul(b1_s, 4'hd) ^
                        gf_mul(b2_s, 4'h9) ^ gf_mul(b3_s, 4'he);

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Iterative InvMixColumns: one shared column helper walks the four columns,
// one per clock; a bypass path serves the final decryption round.
module inv_mix_columns_seq
  import aes_dec_pkg::state_e, aes_dec_pkg::IDLE, aes_dec_pkg::RUN,
         aes_dec_pkg::DONE, aes_dec_pkg::STATE_W, aes_dec_pkg::get_col,
         aes_dec_pkg::set_col;
#(
  parameter int unsigned NUM_COLS = 4,
  parameter int unsigned COL_W    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_bypass,
  input  logic [STATE_W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_data,
  output logic               busy,
  output logic [1:0]         col_idx
);

  localparam logic [1:0] LAST_COL = 2'(NUM_COLS - 1);

  state_e             state_q, state_d;
  logic [STATE_W-1:0] data_q, data_d;
  logic [1:0]         col_q, col_d;
  logic [COL_W-1:0]   col_in_s, col_out_s;

  assign col_in_s = get_col(data_q, col_q);

  inv_mix_columns_seq_col u_col (
    .col_i (col_in_s),
    .col_o (col_out_s)
  );

  // Next-state, datapath and column-counter control; flush overrides everything.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    col_d   = col_q;
    if (flush) begin
      state_d = IDLE;
      col_d   = 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_d  = in_data;
            col_d   = 2'd0;
            state_d = in_bypass ? DONE : RUN;
          end else begin
            state_d = IDLE;
          end
        end
        RUN: begin
          data_d = set_col(data_q, col_q, col_out_s);
          if (col_q == LAST_COL) begin
            col_d   = 2'd0;
            state_d = DONE;
          end else begin
            col_d   = col_q + 2'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end else begin
            state_d = DONE;
          end
        end
        default: begin
          state_d = IDLE;
          col_d   = 2'd0;
        end
      endcase
    end
  end

  // State, working state register and column counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      col_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      col_q   <= col_d;
    end
  end

  // Handshake and status flags decode directly from the state register.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: in_ready = 1'b1;
      RUN:  busy     = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  assign col_idx  = col_q;
  assign out_data = data_q;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Self-checking bench for inv_mix_columns_seq: scenario tasks with a scoreboard
// queue fed at input transfers and drained at output transfers.
module tb_inv_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst_n, flush, in_valid, in_ready, in_bypass;
  logic         out_valid, out_ready, busy;
  logic [127:0] in_data, out_data;
  logic [1:0]   col_idx;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  logic [127:0] exp_q[$];

  localparam logic [127:0] VEC_IN  = 128'h8e4da1bc_d5d5d7d6_4d7ebdf8_01010101;
  localparam logic [127:0] VEC_OUT = 128'hdb135345_d4d4d4d5_2d26314c_01010101;
  localparam logic [127:0] ONES    = 128'h01010101_01010101_01010101_01010101;

  always #5 clk = ~clk;

  inv_mix_columns_seq dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_bypass(in_bypass), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy), .col_idx(col_idx)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Shift-and-add GF(2^8) multiply, reduced by 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s, input logic byp);
    logic [7:0]   m [4];
    logic [7:0]   b [4];
    logic [7:0]   acc;
    logic [127:0] r;
    m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    if (byp) return s;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) b[j] = s[127 - 32*c - 8*j -: 8];
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(m[(j - row + 4) % 4], b[j]);
        r[127 - 32*c - 8*row -: 8] = acc;
      end
    end
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_bypass = 1'b0;
    in_data = '0; out_ready = 1'b0;
    #3;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else pass_cnt++;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    chk_cnt++; if (col_idx !== 2'd0) $display("FAIL reset_col_idx got %0d want 0", col_idx); else pass_cnt++;
    chk_cnt++; if (out_data !== 128'h0) $display("FAIL reset_out_data got %h want 0", out_data); else pass_cnt++;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_vector();
    logic [127:0] e;
    out_ready = 1'b1; in_bypass = 1'b0; in_data = VEC_IN; in_valid = 1'b1;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL vec_in_ready got %b want 1", in_ready); else pass_cnt++;
    exp_q.push_back(VEC_OUT);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_cnt++; if (out_valid !== 1'b0) $display("FAIL vec_run_out_valid cyc %0d got %b want 0", i, out_valid); else pass_cnt++;
      chk_cnt++; if (col_idx !== 2'(i)) $display("FAIL vec_col_idx got %0d want %0d", col_idx, i); else pass_cnt++;
      chk_cnt++; if (in_ready !== 1'b0) $display("FAIL vec_run_in_ready got %b want 0", in_ready); else pass_cnt++;
      tick();
    end
    chk_cnt++; if (out_valid !== 1'b1) $display("FAIL vec_out_valid got %b want 1", out_valid); else pass_cnt++;
    if (out_valid && out_ready && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk_cnt++; if (out_data !== e) $display("FAIL vec_out_data got %h want %h", out_data, e); else pass_cnt++;
    end
    tick();
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL vec_one_cycle got %b want 0", out_valid); else pass_cnt++;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL vec_idle_in_ready got %b want 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_bypass();
    logic [127:0] v, e;
    v = 128'hc6c6c6c6_00112233_deadbeef_0badf00d;
    out_ready = 1'b0; in_bypass = 1'b1; in_data = v; in_valid = 1'b1;
    exp_q.push_back(model(v, 1'b1));
    tick();
    in_valid = 1'b0; in_bypass = 1'b0; in_data = '0;
    chk_cnt++; if (out_valid !== 1'b1) $display("FAIL byp_out_valid got %b want 1", out_valid); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b1) $display("FAIL byp_busy got %b want 1", busy); else pass_cnt++;
    chk_cnt++; if (col_idx !== 2'd0) $display("FAIL byp_col_idx got %0d want 0", col_idx); else pass_cnt++;
    out_ready = 1'b1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk_cnt++; if (out_data !== e) $display("FAIL byp_out_data got %h want %h", out_data, e); else pass_cnt++;
    end
    tick();
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL byp_idle got %b want 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [127:0] e;
    out_ready = 1'b0; in_bypass = 1'b0; in_data = VEC_IN; in_valid = 1'b1;
    exp_q.push_back(VEC_OUT);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10 && out_valid !== 1'b1; i++) tick();
    chk_cnt++; if (out_valid !== 1'b1) $display("FAIL bp_wait_out_valid got %b want 1", out_valid); else pass_cnt++;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_data = {4{$urandom}};
      chk_cnt++; if (out_data !== e) $display("FAIL bp_out_data cyc %0d got %h want %h", i, out_data, e); else pass_cnt++;
      chk_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready cyc %0d got %b want 0", i, in_ready); else pass_cnt++;
      chk_cnt++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid cyc %0d got %b want 1", i, out_valid); else pass_cnt++;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk_cnt++; if (out_data !== e) $display("FAIL bp_release_data got %h want %h", out_data, e); else pass_cnt++;
    tick();
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_after_in_ready got %b want 1", in_ready); else pass_cnt++;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL bp_after_out_valid got %b want 0", out_valid); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL bp_after_busy got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_flush();
    logic [127:0] e;
    logic         ov_seen;
    out_ready = 1'b1; in_bypass = 1'b0; in_data = VEC_IN; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10 && col_idx !== 2'd2; i++) tick();
    chk_cnt++; if (col_idx !== 2'd2) $display("FAIL fl_reach_col2 got %0d want 2", col_idx); else pass_cnt++;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL fl_in_ready got %b want 1", in_ready); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL fl_busy got %b want 0", busy); else pass_cnt++;
    chk_cnt++; if (col_idx !== 2'd0) $display("FAIL fl_col_idx got %0d want 0", col_idx); else pass_cnt++;
    ov_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ov_seen = ov_seen | out_valid;
      tick();
    end
    chk_cnt++; if (ov_seen !== 1'b0) $display("FAIL fl_out_valid_seen got %b want 0", ov_seen); else pass_cnt++;
    // flush together with in_valid in IDLE must not start a transfer
    in_data = ONES; in_valid = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL fl_idle_no_xfer got %b want 0", busy); else pass_cnt++;
    exp_q.push_back(ONES);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10 && out_valid !== 1'b1; i++) tick();
    chk_cnt++; if (out_valid !== 1'b1) $display("FAIL fl_wait_out_valid got %b want 1", out_valid); else pass_cnt++;
    if (out_valid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk_cnt++; if (out_data !== e) $display("FAIL fl_ones_data got %h want %h", out_data, e); else pass_cnt++;
    end
    tick();
  endtask

  task automatic test_async_reset();
    logic [127:0] e;
    out_ready = 1'b1; in_bypass = 1'b0; in_data = VEC_IN; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL ar_out_valid got %b want 0", out_valid); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL ar_busy got %b want 0", busy); else pass_cnt++;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL ar_in_ready got %b want 1", in_ready); else pass_cnt++;
    chk_cnt++; if (col_idx !== 2'd0) $display("FAIL ar_col_idx got %0d want 0", col_idx); else pass_cnt++;
    chk_cnt++; if (out_data !== 128'h0) $display("FAIL ar_out_data got %h want 0", out_data); else pass_cnt++;
    #2;
    rst_n = 1'b1;
    tick();
    in_data = VEC_IN; in_valid = 1'b1;
    exp_q.push_back(model(VEC_IN, 1'b0));
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10 && out_valid !== 1'b1; i++) tick();
    chk_cnt++; if (out_valid !== 1'b1) $display("FAIL ar_wait_out_valid got %b want 1", out_valid); else pass_cnt++;
    if (out_valid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk_cnt++; if (out_data !== e) $display("FAIL ar_vec_data got %h want %h", out_data, e); else pass_cnt++;
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [127:0] v [3];
    logic [127:0] e;
    int sent, rcvd, last_t, cyc;
    sent = 0; rcvd = 0; last_t = -1; cyc = 0;
    for (int i = 0; i < 3; i++) v[i] = {$urandom, $urandom, $urandom, $urandom};
    out_ready = 1'b1; in_bypass = 1'b0; in_data = v[0]; in_valid = 1'b1;
    while (rcvd < 3 && cyc < 100) begin
      if (in_valid && in_ready) begin
        chk_cnt++; if (busy !== 1'b0) $display("FAIL b2b_busy_at_xfer got %b want 0", busy); else pass_cnt++;
        if (last_t >= 0) begin
          chk_cnt++; if (cyc - last_t != 6) $display("FAIL b2b_interval got %0d want 6", cyc - last_t); else pass_cnt++;
        end
        last_t = cyc;
        exp_q.push_back(model(v[sent], 1'b0));
        sent++;
      end
      if (out_valid && out_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
        chk_cnt++; if (out_data !== e) $display("FAIL b2b_data %0d got %h want %h", rcvd, out_data, e); else pass_cnt++;
        rcvd++;
      end
      tick();
      cyc++;
      if (sent < 3) in_data = v[sent]; else in_valid = 1'b0;
    end
    in_valid = 1'b0;
    chk_cnt++; if (rcvd != 3) $display("FAIL b2b_timeout got %0d want 3 results", rcvd); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_vector();
    test_bypass();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_back_to_back();
    chk_cnt++; if (exp_q.size() != 0) $display("FAIL sb_leftover got %0d want 0", exp_q.size()); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
